// File: rtl/deco_onehot_sel_n.sv
// One-hot select decoder: registered direct compare (latency 1) or fixed-latency bit-serial scan.
// Define DECO_STATS_EN to build the saturating match/miss counters; otherwise they read as 0.

module deco_onehot_sel_n #(
    parameter int N     = 8,
    parameter int SW    = $clog2(N),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     datos_in,
    input  logic [SW-1:0]    sel,
    input  logic             in_valid,
    input  logic             modo,
    input  logic             err_clr,
    output logic             busy,
    output logic             out,
    output logic             out_valid,
    output logic [SW-1:0]    idx,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [SW:0]   N_V    = (SW+1)'(N);
    localparam logic [SW-1:0] K_LAST = SW'(N - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    typedef struct packed {
        logic          out;
        logic [SW-1:0] idx;
        logic          err;
    } res_t;

    // Set-bit count only needs to distinguish 0, 1 and "more than one".
    function automatic logic [1:0] f_sat_inc(input logic [1:0] c);
        return (c == 2'd2) ? c : c + 2'd1;
    endfunction

    function automatic res_t f_result(input logic [1:0] ones, input logic [SW-1:0] first,
                                      input logic bit_at_sel, input logic [SW-1:0] s);
        res_t r;
        logic legal;
        logic sel_ok;
        legal  = (ones == 2'd1);
        sel_ok = ({1'b0, s} < N_V);
        r.out  = legal & sel_ok & bit_at_sel;
        r.idx  = first;
        r.err  = ~legal | ~sel_ok;
        return r;
    endfunction

    state_t        r_state, w_state_nx;
    logic [N-1:0]  r_data;
    logic [SW-1:0] r_sel, r_k, r_first, r_idx;
    logic [1:0]    r_ones;
    logic          r_out, r_out_valid, r_err, r_err_sticky;

    logic [1:0]    w_d_ones, w_s_ones;
    logic [SW-1:0] w_d_first, w_s_first;
    logic          w_s_bit, w_load, w_res_we;
    res_t          w_res;

    always_comb begin
        w_d_ones  = 2'd0;
        w_d_first = '0;
        for (int i = 0; i < N; i++) begin
            if (datos_in[i]) begin
                if (w_d_ones == 2'd0) w_d_first = SW'(i);
                w_d_ones = f_sat_inc(w_d_ones);
            end
        end
    end

    // One captured bit per SCAN cycle; same counting rule as the direct path.
    assign w_s_bit   = r_data[r_k];
    assign w_s_ones  = w_s_bit ? f_sat_inc(r_ones) : r_ones;
    assign w_s_first = (w_s_bit && r_ones == 2'd0) ? r_k : r_first;

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_res_we   = 1'b0;
        w_res      = '0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load = 1'b1;
                    if (modo) begin
                        w_state_nx = SCAN;
                    end else begin
                        w_res_we = 1'b1;
                        w_res    = f_result(w_d_ones, w_d_first, datos_in[sel], sel);
                    end
                end
            end
            SCAN: begin
                if (r_k == K_LAST) begin
                    w_state_nx = DONE;
                    w_res_we   = 1'b1;
                    w_res      = f_result(w_s_ones, w_s_first, r_data[r_sel], r_sel);
                end
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k          <= '0;
            r_ones       <= 2'd0;
            r_first      <= '0;
            r_out        <= 1'b0;
            r_idx        <= '0;
            r_err        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_out_valid <= w_res_we;
            if (w_res_we) begin
                r_out <= w_res.out;
                r_idx <= w_res.idx;
                r_err <= w_res.err;
            end
            if (w_load) begin
                r_k     <= '0;
                r_ones  <= 2'd0;
                r_first <= '0;
            end else if (r_state == SCAN) begin
                r_k     <= r_k + 1'b1;
                r_ones  <= w_s_ones;
                r_first <= w_s_first;
            end
            // An error being reported now or next cycle overrides a clear.
            r_err_sticky <= (w_res_we & w_res.err) | (r_out_valid & r_err)
                          | (r_err_sticky & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_data <= datos_in;
            r_sel  <= sel;
        end
    end

    assign busy       = (r_state == SCAN);
    assign out        = r_out;
    assign out_valid  = r_out_valid;
    assign idx        = r_idx;
    assign err        = r_err;
    assign err_sticky = r_err_sticky;

`ifdef DECO_STATS_EN
    logic [CNT_W-1:0] r_match_cnt, r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
        end else if (w_res_we) begin
            if (w_res.out) begin
                if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + 1'b1;
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign match_cnt = r_match_cnt;
    assign miss_cnt  = r_miss_cnt;
`else
    assign match_cnt = '0;
    assign miss_cnt  = '0;
`endif

endmodule
